// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
package regfile_pkg;

  localparam int N_REG  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requesters, issue marking and register file write port
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [N_REG-1:0]  pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, iss_valid, iss_addr,
    input  a_ready, b_ready, we3, wa3, wd3, pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, iss_valid, iss_addr,
    output a_ready, b_ready, we3, wa3, wd3, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_arb2.sv
// rtl/regfile_wb_arbiter_arb2.sv - 2-way one-hot grant; WB_ARB_RR_EN selects round-robin ties,
// otherwise fixed priority with B (load) winning ties and A starvable under continuous B traffic.
module wb_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic    w_tie;
  req_id_e w_tie_winner;

  assign w_tie = i_valid[0] & i_valid[1];

`ifdef WB_ARB_RR_EN
  req_id_e r_prio;

  // Pointer names the next tie winner and only moves when a tie is resolved.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= REQ_A;
    end else if (w_tie) begin
      r_prio <= (r_prio == REQ_A) ? REQ_B : REQ_A;
    end
  end

  assign w_tie_winner = r_prio;
`else
  logic w_unused_clk;

  assign w_unused_clk = clk;
  assign w_tie_winner = REQ_B;
`endif

  always_comb begin
    o_grant = 2'b00;
    if (!reset) begin
      if (w_tie) begin
        o_grant = (w_tie_winner == REQ_B) ? 2'b10 : 2'b01;
      end else begin
        o_grant = i_valid;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between A and B and tracks
// pending producers; tie policy set by WB_ARB_RR_EN (see wb_arb2).
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  logic [1:0]        w_grant;
  wb_req_t           w_req;
  logic              w_accept;
  logic              w_write;
  logic [N_REG-1:0]  w_pending_nxt;

  logic              r_we3;
  logic [ADDR_W-1:0] r_wa3;
  logic [DATA_W-1:0] r_wd3;
  logic [N_REG-1:0]  r_pending;

  wb_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_valid ({bus.b_valid, bus.a_valid}),
    .o_grant (w_grant)
  );

  assign bus.a_ready = w_grant[0];
  assign bus.b_ready = w_grant[1];

  always_comb begin
    w_req = '{addr: bus.a_addr, data: bus.a_data};
    if (w_grant[1]) begin
      w_req = '{addr: bus.b_addr, data: bus.b_data};
    end
  end

  assign w_accept = |w_grant;
  // Writes to the zero register are handshaken normally but never reach the port.
  assign w_write  = w_accept && (w_req.addr != ZERO_REG);

  // Issue is applied after the commit clear so a new producer supersedes the retiring one.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_we3) begin
      w_pending_nxt[r_wa3] = 1'b0;
    end
    if (bus.iss_valid) begin
      w_pending_nxt[bus.iss_addr] = 1'b1;
    end
    w_pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we3     <= 1'b0;
      r_wa3     <= '0;
      r_wd3     <= '0;
      r_pending <= '0;
    end else begin
      r_we3     <= w_write;
      r_pending <= w_pending_nxt;
      if (w_write) begin
        r_wa3 <= w_req.addr;
        r_wd3 <= w_req.data;
      end
    end
  end

  assign bus.we3     = r_we3;
  assign bus.wa3     = r_wa3;
  assign bus.wd3     = r_wd3;
  assign bus.pending = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random checks of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file seen by the DUT write port; writes are gated while the core is in reset.
  logic [DATA_W-1:0] rf [N_REG];
  always @(posedge clk) begin
    if (bus.we3 && !reset) rf[bus.wa3] <= bus.wd3;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs for the current cycle, advanced once per cycle.
  logic              m_we3;
  logic [ADDR_W-1:0] m_wa3;
  logic [DATA_W-1:0] m_wd3;
  logic [N_REG-1:0]  m_pend;
  logic [DATA_W-1:0] m_x [N_REG];
  req_id_e           m_last_tie;
  logic              e_ar, e_br;
  logic              p_av, p_ar, p_bv, p_br, p_rst;
  logic [ADDR_W-1:0] p_aa, p_ba;
  logic [DATA_W-1:0] p_ad, p_bd;

  always @(negedge clk) begin
    e_ar = 1'b0;
    e_br = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
`ifdef WB_ARB_RR_EN
        if (m_last_tie == REQ_B) e_ar = 1'b1; else e_br = 1'b1;
`else
        e_br = 1'b1;
`endif
      end else begin
        e_ar = bus.a_valid;
        e_br = bus.b_valid;
      end
    end
    chk("a_ready", bus.a_ready, e_ar);
    chk("b_ready", bus.b_ready, e_br);
    chk("we3", bus.we3, m_we3);
    if (m_we3) begin
      chk("wa3", bus.wa3, m_wa3);
      chk("wd3", bus.wd3, m_wd3);
    end
    chk("pending", bus.pending, m_pend);
    for (int i = 0; i < N_REG; i++) chk($sformatf("rf[%0d]", i), rf[i], m_x[i]);
    if (p_av && !p_ar && !p_rst && !reset)
      chk("protocol_a", {bus.a_valid, bus.a_addr, bus.a_data}, {1'b1, p_aa, p_ad});
    if (p_bv && !p_br && !p_rst && !reset)
      chk("protocol_b", {bus.b_valid, bus.b_addr, bus.b_data}, {1'b1, p_ba, p_bd});
    {p_av, p_ar, p_aa, p_ad} = {bus.a_valid, bus.a_ready, bus.a_addr, bus.a_data};
    {p_bv, p_br, p_ba, p_bd} = {bus.b_valid, bus.b_ready, bus.b_addr, bus.b_data};
    p_rst = reset;

    if (reset) begin
      m_we3 = 1'b0;
      m_wa3 = '0;
      m_wd3 = '0;
      m_pend = '0;
      m_last_tie = REQ_B;
    end else begin
      if (m_we3) begin
        m_x[m_wa3] = m_wd3;
        m_pend[m_wa3] = 1'b0;
      end
      if (bus.iss_valid) m_pend[bus.iss_addr] = 1'b1;
      m_pend[31] = 1'b0;
      if (bus.a_valid && bus.b_valid) m_last_tie = e_ar ? REQ_A : REQ_B;
      m_we3 = 1'b0;
      if (e_ar && bus.a_addr != 5'd31) begin
        m_we3 = 1'b1; m_wa3 = bus.a_addr; m_wd3 = bus.a_data;
      end
      if (e_br && bus.b_addr != 5'd31) begin
        m_we3 = 1'b1; m_wa3 = bus.b_addr; m_wd3 = bus.b_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic              ar, br, a_hs, b_hs, last_g;
  int                ga, gb, runs;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < N_REG; i++) begin
      rf[i] = '0;
      m_x[i] = '0;
    end
    m_we3 = 1'b0; m_wa3 = '0; m_wd3 = '0; m_pend = '0; m_last_tie = REQ_B;
    {p_av, p_ar, p_bv, p_br, p_rst} = 5'b00001;
    p_aa = '0; p_ba = '0; p_ad = '0; p_bd = '0;
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 64'h1;
    bus.b_valid = 1'b0; bus.b_addr = '0;   bus.b_data = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_we3", bus.we3, 1'b0);
    chk("rst_wa3", bus.wa3, 5'd0);
    chk("rst_wd3", bus.wd3, 64'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    tick();
    bus.a_valid = 1'b0;
    reset = 1'b0;

    // Single writer
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'hDEAD;
    @(negedge clk);
    chk("single_a_ready", bus.a_ready, 1'b1);
    tick();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("single_we3", bus.we3, 1'b1);
    chk("single_wa3", bus.wa3, 5'd5);
    chk("single_wd3", bus.wd3, 64'hDEAD);
    tick();
    @(negedge clk);
    chk("single_we3_off", bus.we3, 1'b0);
    chk("single_x5", rf[5], 64'hDEAD);

    // Tie on the same destination
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 64'h22;
    @(negedge clk);
`ifdef WB_ARB_RR_EN
    chk("tie_first_a", bus.a_ready, 1'b1);
`else
    chk("tie_first_b", bus.b_ready, 1'b1);
`endif
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      ar = bus.a_ready; br = bus.b_ready;
      tick();
      if (ar) bus.a_valid = 1'b0;
      if (br) bus.b_valid = 1'b0;
    end
    chk("tie_drained", {bus.a_valid, bus.b_valid}, 2'b00);
    tick(); tick();
    @(negedge clk);
`ifdef WB_ARB_RR_EN
    chk("tie_x3", rf[3], 64'h22);
`else
    chk("tie_x3", rf[3], 64'h11);
`endif

    // Zero register write
    tick();
    bus.a_valid = 1'b1; bus.a_addr = 5'd31; bus.a_data = 64'hFF;
    @(negedge clk);
    chk("zero_a_ready", bus.a_ready, 1'b1);
    tick();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("zero_we3", bus.we3, 1'b0);
    chk("zero_pending31", bus.pending[31], 1'b0);
    tick();
    @(negedge clk);
    chk("zero_x31", rf[31], 64'd0);

    // Scoreboard set and clear, then simultaneous set/clear
    tick();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("sb_set7", bus.pending[7], 1'b1);
    tick();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'h77;
    tick();
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("sb_still7", bus.pending[7], 1'b1);
    tick();
    @(negedge clk);
    chk("sb_clear7", bus.pending[7], 1'b0);
    tick();
    bus.b_valid = 1'b1; bus.b_data = 64'h78;
    tick();
    bus.b_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("sb_set_wins7", bus.pending[7], 1'b1);
    tick();
    @(negedge clk);
    chk("sb_hold7", bus.pending[7], 1'b1);

    // Sustained tie for 8 cycles
    tick();
    ga = 0; gb = 0; runs = 0; last_g = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd10; bus.a_data = 64'hA0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd11; bus.b_data = 64'hB0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ar = bus.a_ready; br = bus.b_ready;
      if (ar) ga++;
      if (br) gb++;
      if (c != 0 && br == last_g) runs++;
      last_g = br;
      tick();
      if (ar) begin bus.a_addr = 5'($urandom_range(10, 20)); bus.a_data = {32'h0, $urandom}; end
      if (br) begin bus.b_addr = 5'($urandom_range(10, 20)); bus.b_data = {32'h0, $urandom}; end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
`ifdef WB_ARB_RR_EN
    chk("fair_ga", 64'(ga), 64'd4);
    chk("fair_gb", 64'(gb), 64'd4);
    chk("fair_repeats", 64'(runs), 64'd0);
`else
    chk("fixed_ga", 64'(ga), 64'd0);
    chk("fixed_gb", 64'(gb), 64'd8);
`endif

    // Reset while a write is in flight
    tick(); tick();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 64'h55;
    @(negedge clk);
    chk("rmid_a_ready", bus.a_ready, 1'b1);
    tick();
    bus.a_valid = 1'b0; bus.iss_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_inflight", bus.we3, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_we3", bus.we3, 1'b0);
    chk("rmid_pending", bus.pending, 32'd0);
    chk("rmid_x9", rf[9], 64'd0);

    // Random traffic
    tick();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_hs = bus.a_valid & bus.a_ready;
      b_hs = bus.b_valid & bus.b_ready;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (!bus.a_valid || a_hs) begin
        bus.a_valid = ($urandom_range(0, 2) != 0);
        bus.a_addr  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
        bus.a_data  = {$urandom, $urandom};
      end
      if (!bus.b_valid || b_hs) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_addr  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
        bus.b_data  = {$urandom, $urandom};
      end
      bus.iss_valid = $urandom_range(0, 1) != 0;
      bus.iss_addr  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.iss_valid = 1'b0; reset = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (memory/load). Each requester uses a valid/ready handshake. Drives we3/wa3/wd3 from a registered stage. Also keeps a pending-write scoreboard that decode uses to stall reads of registers with an outstanding producer.

Parameters:
N_REG, 32, number of architectural registers
ADDR_W, 5, register address width
DATA_W, 64, write data width
ZERO_REG, 31, hardwired-zero register index (XZR); writes to it are discarded

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
a_valid  in  1  requester A has a write
a_ready  out  1  A's write accepted this cycle (combinational)
a_addr  in  ADDR_W  A's destination register
a_data  in  DATA_W  A's write data
b_valid  in  1  requester B has a write
b_ready  out  1  B's write accepted this cycle (combinational)
b_addr  in  ADDR_W  B's destination register
b_data  in  DATA_W  B's write data
iss_valid  in  1  decode issued an instruction that will write iss_addr
iss_addr  in  ADDR_W  register to mark pending
we3  out  1  register file write enable (registered)
wa3  out  ADDR_W  register file write address (registered)
wd3  out  DATA_W  register file write data (registered)
pending  out  N_REG  bit i = register i has an outstanding write (registered)

Behaviour:
- Reset: we3=0, wa3=0, wd3=0, pending=0, a_ready=b_ready=0 while reset=1, priority pointer = A.
- Handshake: transfer occurs on a posedge where valid&&ready.
  - Requester holds valid, addr and data stable until ready.
  - Dropping valid before acceptance is a protocol error (bench assertion).
- Arbitration: at most one grant per cycle; the write port never backpressures.
  - Exactly one valid: that requester is granted.
  - Both valid: winner chosen by the priority rule (see Optional Feature).
- Latency: write accepted at edge t.
  - Cycle t..t+1: we3=1, wa3/wd3 = accepted addr/data.
  - Register file captures at edge t+1.
  - No grant at edge t: we3=0 in the following cycle; wa3/wd3 hold their last value.
- ZERO_REG: a write to ZERO_REG is accepted (ready=1) but produces we3=0. pending[ZERO_REG] is constant 0.
- Scoreboard:
  - Set: iss_valid=1 sets pending[iss_addr] at the next edge.
  - Clear: pending[wa3] clears at the edge where we3=1 is captured.
  - Same address set and clear at the same edge: set wins (a new producer supersedes).
  - Set of an already pending bit: stays 1; no counting, single outstanding producer assumed.
- Same destination from A and B in the same cycle: serialized in grant order; the later grant's data is the final value.
- Reset mid-operation: any in-flight write is dropped (we3=0 the cycle after reset). Requesters must re-present after reset.
- No combinational path from we3/wa3 to a_ready/b_ready. Ready depends only on valids and the priority pointer.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: 2-way round-robin. On a tie, the requester not granted most recently wins. The pointer updates only on a tie grant.
- Undefined: fixed priority, B (load) beats A on a tie. Starvation of A under continuous B traffic is permitted and documented. No pointer flop is synthesized.

Decomposition:
- Package regfile_pkg:
  - Constants N_REG, ADDR_W, DATA_W, ZERO_REG.
  - typedef wb_req_t (struct: addr, data).
  - typedef req_id_e (REQ_A, REQ_B).
- Sub-module wb_arb2: combinational 2-way grant plus the optional round-robin pointer flop. Takes the two valids and returns one-hot grant.
- Output register and scoreboard stay in regfile_wb_arbiter.

Test Plan:
- Single writer: A writes addr 5, data 0xDEAD at edge t → we3=1, wa3=5, wd3=0xDEAD during t..t+1; then we3=0; the register file reads 0xDEAD at X5.
- Tie:
  - Without WB_ARB_RR_EN: A(3,0x11) and B(3,0x22) both valid → B granted first, A next cycle; final X3=0x11.
  - With the macro from reset: A first, then B; final X3=0x22.
- ZERO_REG: A writes addr 31, data 0xFF → a_ready=1, we3 stays 0, pending[31]=0, X31 reads 0.
- Scoreboard: iss_valid with addr 7 → pending[7]=1 next cycle; B writes 7 → pending[7]=0 after the we3 edge. Simultaneous iss(7) and commit(7) → pending[7] stays 1.
- Round-robin fairness (WB_ARB_RR_EN): both valid for 8 cycles → grants alternate A,B,A,B…; 4 each, no requester waits more than 1 cycle.
- Reset mid-op: accept A(9,0x55), assert reset the next cycle → we3=0, pending=0, X9 unchanged.
